// File: rtl/mac_pkg.sv
// Shared constants, index widths and FSM state encoding for the MAC operand sequencer.
package mac_pkg;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned AW = 10;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IW = idx_width(N * N);  // flat element index row*N+col
    localparam int unsigned CW = idx_width(N);      // row, column and k counters

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StAcc,
        StCap,
        StOut,
        StDone
    } state_e;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Host write/start, MAC operand bus and result stream of the MAC operand sequencer.
interface mac_operand_sequencer_if;
    import mac_pkg::*;

    logic          wr_en;
    logic          wr_sel;
    logic [IW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] mac_w;
    logic [DW-1:0] mac_x;
    logic          mac_load;
    logic          mac_clear;
    logic [AW-1:0] mac_o;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic [IW-1:0] res_idx;

    modport master (
        input  wr_en, wr_sel, wr_addr, wr_data, start, mac_o, res_ready,
        output busy, done, mac_w, mac_x, mac_load, mac_clear, res_valid, res_data, res_idx
    );

    modport slave (
        output wr_en, wr_sel, wr_addr, wr_data, start, mac_o, res_ready,
        input  busy, done, mac_w, mac_x, mac_load, mac_clear, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/mac_matrix_rf.sv
// NxN register file: async clear, one write port by flat index, one combinational
// read port by (row, col).
module mac_matrix_rf
    import mac_pkg::*;
(
    input  logic          clk,
    input  logic          clear,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [CW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned NE = N * N;

    logic [DW-1:0] mem_q [NE];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int unsigned e = 0; e < NE; e++) mem_q[e] <= '0;
        end else if (we_i) begin
            // Indexes >= N*N match no entry and are dropped.
            for (int unsigned e = 0; e < NE; e++) begin
                if (waddr_i == IW'(e)) mem_q[e] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                if (row_i == CW'(r) && col_i == CW'(c)) rdata_o = mem_q[r * N + c];
            end
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Sequences A x B through an external MAC: clear, N accumulates, capture, then
// hands each C[i][j] out on a valid/ready stream in row-major order.
module mac_operand_sequencer
    import mac_pkg::*;
(
    input logic                     clk,
    input logic                     clear,
    mac_operand_sequencer_if.master seq_io
);

    state_e        state_q;
    logic [CW-1:0] i_q, j_q, k_q;
    logic          busy_q, done_q, load_q, mclr_q, valid_q;
    logic [AW-1:0] data_q;
    logic [IW-1:0] idx_q;

    logic          rf_we;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          last_k, last_elem;
    logic [IW-1:0] elem_idx;

    // Storage only changes while idle, so it is stable for the whole product.
    assign rf_we = seq_io.wr_en && (state_q == StIdle);

    mac_matrix_rf u_rf_a (
        .clk     (clk),
        .clear   (clear),
        .we_i    (rf_we && !seq_io.wr_sel),
        .waddr_i (seq_io.wr_addr),
        .wdata_i (seq_io.wr_data),
        .row_i   (i_q),
        .col_i   (k_q),
        .rdata_o (a_rdata)
    );

    mac_matrix_rf u_rf_b (
        .clk     (clk),
        .clear   (clear),
        .we_i    (rf_we && seq_io.wr_sel),
        .waddr_i (seq_io.wr_addr),
        .wdata_i (seq_io.wr_data),
        .row_i   (k_q),
        .col_i   (j_q),
        .rdata_o (b_rdata)
    );

    assign last_k    = (k_q == CW'(N - 1));
    assign last_elem = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
    assign elem_idx  = IW'(i_q) * IW'(N) + IW'(j_q);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            mclr_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (seq_io.start) begin
                        state_q <= StClr;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        mclr_q  <= 1'b1;
                    end
                end
                StClr: begin
                    state_q <= StAcc;
                    k_q     <= '0;
                    mclr_q  <= 1'b0;
                    load_q  <= 1'b1;
                end
                StAcc: begin
                    if (last_k) begin
                        state_q <= StCap;
                        load_q  <= 1'b0;
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                end
                StCap: begin
                    // The last accumulate landed on the edge entering this state.
                    state_q <= StOut;
                    valid_q <= 1'b1;
                    data_q  <= seq_io.mac_o;
                    idx_q   <= elem_idx;
                end
                StOut: begin
                    if (seq_io.res_ready) begin
                        valid_q <= 1'b0;
                        if (last_elem) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StClr;
                            mclr_q  <= 1'b1;
                            if (j_q == CW'(N - 1)) begin
                                j_q <= '0;
                                i_q <= i_q + CW'(1);
                            end else begin
                                j_q <= j_q + CW'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    load_q  <= 1'b0;
                    mclr_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq_io.busy      = busy_q;
    assign seq_io.done      = done_q;
    assign seq_io.mac_load  = load_q;
    assign seq_io.mac_clear = mclr_q;
    assign seq_io.mac_w     = (state_q == StAcc) ? a_rdata : '0;
    assign seq_io.mac_x     = (state_q == StAcc) ? b_rdata : '0;
    assign seq_io.res_valid = valid_q;
    assign seq_io.res_data  = data_q;
    assign seq_io.res_idx   = idx_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: behavioural MAC and matrix-product model checked
// every cycle, plus hand-computed result tables per directed scenario.
module tb_mac_operand_sequencer;
    import mac_pkg::*;

    localparam int D  = int'(N);
    localparam int NE = D * D;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    mac_operand_sequencer_if bus ();

    mac_operand_sequencer dut (
        .clk    (clk),
        .clear  (clear),
        .seq_io (bus)
    );

    // External MAC: accumulator updates on the edge that samples load/clear.
    logic [AW-1:0] acc_q;
    always @(posedge clk or posedge clear) begin
        if (clear)              acc_q <= '0;
        else if (bus.mac_clear) acc_q <= '0;
        else if (bus.mac_load)  acc_q <= acc_q + AW'(bus.mac_w) * AW'(bus.mac_x);
    end
    assign bus.mac_o = acc_q;

    int          checks   = 0;
    int          failures = 0;
    int          am [NE];
    int          bm [NE];
    int          got [NE];
    int          lit_exp [NE];
    bit          lit_en   = 1'b0;
    int          lit_cyc  = 0;
    int          tmo_cnt  = 0;
    int          tmo_seen = 0;
    bit          exp_busy = 1'b0;
    int          elem     = 0;
    int          kcnt     = 0;
    int          cyc      = 0;
    int          n_res    = 0;
    bit          seen_clr = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_hs    = 1'b0;
    logic [31:0] prev_di    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cexp(input int e);
        int s;
        s = 0;
        if (e >= NE) return -1;
        for (int k = 0; k < D; k++) s += am[(e / D) * D + k] * bm[k * D + (e % D)];
        return s;
    endfunction

    always @(negedge clk) begin
        if (clear) begin
            chk("reset_outputs", 32'({bus.busy, bus.done, bus.mac_load, bus.mac_clear,
                bus.res_valid, bus.res_data, bus.res_idx, bus.mac_w, bus.mac_x}), 32'd0);
            for (int e = 0; e < NE; e++) begin
                am[e] = 0;
                bm[e] = 0;
            end
            exp_busy   = 1'b0;
            elem       = 0;
            kcnt       = 0;
            seen_clr   = 1'b0;
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            cyc++;
            if (tmo_cnt != tmo_seen) begin
                chk("wait_timeout", 32'(tmo_cnt), 32'(tmo_seen));
                tmo_seen = tmo_cnt;
            end
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("load_clear_exclusive", 32'(bus.mac_load & bus.mac_clear), 32'd0);

            if (bus.mac_load) begin
                chk("loads_within_element", 32'(kcnt < D), 32'd1);
                if (kcnt < D && elem < NE) begin
                    chk("mac_w", 32'(bus.mac_w), 32'(am[(elem / D) * D + kcnt]));
                    chk("mac_x", 32'(bus.mac_x), 32'(bm[kcnt * D + (elem % D)]));
                end
                kcnt++;
            end else begin
                chk("mac_operands_idle", 32'({bus.mac_w, bus.mac_x}), 32'd0);
            end

            if (bus.mac_clear) begin
                if (seen_clr) chk("loads_per_element", 32'(kcnt), 32'(D));
                seen_clr = 1'b1;
                kcnt     = 0;
            end

            if (prev_hs) chk("valid_drops_after_handshake", 32'(bus.res_valid), 32'd0);
            if (prev_stall) begin
                chk("stall_valid_held", 32'(bus.res_valid), 32'd1);
                chk("stall_data_idx_held", 32'({bus.res_data, bus.res_idx}), prev_di);
            end

            if (bus.res_valid) begin
                chk("no_mac_during_out", 32'({bus.mac_load, bus.mac_clear}), 32'd0);
                chk("res_idx", 32'(bus.res_idx), 32'(elem));
                chk("res_data", 32'(bus.res_data), 32'(cexp(elem)));
                chk("loads_before_capture", 32'(kcnt), 32'(D));
                if (bus.res_ready) begin
                    if (int'(bus.res_idx) < NE) got[bus.res_idx] = int'(bus.res_data);
                    elem++;
                    n_res++;
                end
            end
            prev_stall = bus.res_valid && !bus.res_ready;
            prev_hs    = bus.res_valid && bus.res_ready;
            prev_di    = 32'({bus.res_data, bus.res_idx});

            if (bus.done) begin
                chk("done_after_all_results", 32'(elem), 32'(NE));
                if (lit_en) begin
                    for (int e = 0; e < NE; e++) chk("table_c", 32'(got[e]), 32'(lit_exp[e]));
                end
                if (lit_cyc != 0) chk("start_to_done_cycles", 32'(cyc), 32'(lit_cyc));
                elem = 0;
            end

            // Storage model: a write counts only while idle; it lands before a same-cycle start.
            if (!exp_busy && bus.wr_en && int'(bus.wr_addr) < NE) begin
                if (bus.wr_sel) bm[bus.wr_addr] = int'(bus.wr_data);
                else            am[bus.wr_addr] = int'(bus.wr_data);
            end

            if (bus.done) begin
                exp_busy = 1'b0;
            end else if (!exp_busy && bus.start) begin
                exp_busy = 1'b1;
                elem     = 0;
                kcnt     = 0;
                seen_clr = 1'b0;
                cyc      = 0;
                n_res    = 0;
                for (int e = 0; e < NE; e++) got[e] = -1;
            end
        end
    end

    task automatic wr(input bit sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = IW'(addr);
        bus.wr_data = DW'(data);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!bus.done && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) tmo_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.wr_en     = 1'b0;
        bus.wr_sel    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;

        // 1: identity times 1..9
        for (int e = 0; e < NE; e++) wr(1'b0, e, (e / D == e % D) ? 1 : 0);
        for (int e = 0; e < NE; e++) wr(1'b1, e, e + 1);
        for (int e = 0; e < NE; e++) lit_exp[e] = e + 1;
        lit_en  = 1'b1;
        lit_cyc = 55;
        pulse_start();
        wait_done(200);

        // 2: all-15 operands give the maximum sum
        for (int e = 0; e < NE; e++) wr(1'b0, e, 15);
        for (int e = 0; e < NE; e++) wr(1'b1, e, 15);
        for (int e = 0; e < NE; e++) lit_exp[e] = 675;
        pulse_start();
        wait_done(200);

        // 3: A = 1..9, B = ones -> row sums; stall element 4 for 5 cycles
        for (int e = 0; e < NE; e++) wr(1'b0, e, e + 1);
        for (int e = 0; e < NE; e++) wr(1'b1, e, 1);
        for (int e = 0; e < NE; e++) lit_exp[e] = 6 + 9 * (e / D);
        lit_cyc = 60;
        pulse_start();
        n = 0;
        while (!(bus.mac_clear && n_res == 4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) tmo_cnt++;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) tmo_cnt++;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        wait_done(200);

        // 4: start and a write of A[0]=7 while busy are both ignored
        lit_cyc = 55;
        pulse_start();
        n = 0;
        while (n_res != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) tmo_cnt++;
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = DW'(7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        wait_done(200);

        // 5: clear during ACC of element 2, then a fresh product of zeroed storage
        lit_en  = 1'b0;
        lit_cyc = 0;
        pulse_start();
        n = 0;
        while (!(n_res == 2 && bus.mac_load) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) tmo_cnt++;
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int e = 0; e < NE; e++) lit_exp[e] = 0;
        lit_en  = 1'b1;
        lit_cyc = 55;
        pulse_start();
        wait_done(200);

        // 6: index 9 ignored; A[8] written in the same cycle as start
        wr(1'b1, 8, 15);
        wr(1'b0, 9, 15);
        wr(1'b1, 9, 15);
        lit_exp[8] = 225;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = IW'(8);
        bus.wr_data = DW'(15);
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_done(200);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule
